bit_synchronizer: RTL and testbench



---
 rtl/bit_synchronizer_pkg.sv | 9 +
 rtl/sync_bit_chain.sv | 32 +++
 rtl/bit_synchronizer.sv | 40 ++++
 tb/tb_bit_synchronizer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/bit_synchronizer_pkg.sv
// Shared constants for the bit synchronizer slice.
//   SYNC_DEFAULT_STAGES : chain depth used when the instantiator does not choose one
//   SYNC_MIN_STAGES     : shallowest chain that still gives a metastability settling stage
package bit_synchronizer_pkg;

   localparam int SYNC_DEFAULT_STAGES = 4;
   localparam int SYNC_MIN_STAGES     = 2;

endpackage : bit_synchronizer_pkg

// File: rtl/sync_bit_chain.sv
// Single-bit synchronizer chain of NUM_STAGES flops in the CLK domain.
//   CLK : destination clock, rising edge
//   RST : synchronous active-high reset, clears every stage
//   d   : asynchronous input bit
//   q   : synchronized output, driven straight from the last stage
module sync_bit_chain
   import bit_synchronizer_pkg::*;
#(
   parameter int NUM_STAGES = SYNC_DEFAULT_STAGES
)(
   input  logic CLK,
   input  logic RST,
   input  logic d,
   output logic q
);

   // Attributes keep the tools from retiming, merging or packing these
   // flops into an SRL, which would defeat the settling time.
   (* ASYNC_REG = "TRUE", dont_touch = "true" *)
   logic [NUM_STAGES-1:0] stage;

   always_ff @(posedge CLK) begin
      if (RST) begin
         stage <= '0;
      end else begin
         stage <= {stage[NUM_STAGES-2:0], d};
      end
   end

   assign q = stage[NUM_STAGES-1];

endmodule : sync_bit_chain

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for quasi-static level bits entering the CLK domain.
// Each bit has its own independent chain; no cross-bit coherence is implied,
// so multi-bit values must be Gray coded or handshaked by the user.
//   CLK   : destination clock, rising edge
//   RST   : synchronous active-high reset, clears all stages of all bits
//   ASYNC : BUS_WIDTH asynchronous input bits
//   SYNC  : BUS_WIDTH synchronized bits, latency NUM_STAGES cycles, registered
module bit_synchronizer
   import bit_synchronizer_pkg::*;
#(
   parameter int BUS_WIDTH  = 1,
   parameter int NUM_STAGES = SYNC_DEFAULT_STAGES
)(
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [BUS_WIDTH-1:0] ASYNC,
   output logic [BUS_WIDTH-1:0] SYNC
);

   if (NUM_STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
      $fatal(1, "bit_synchronizer: NUM_STAGES=%0d below minimum %0d",
             NUM_STAGES, SYNC_MIN_STAGES);
   end

   if (BUS_WIDTH < 1) begin : g_bad_width
      $fatal(1, "bit_synchronizer: BUS_WIDTH=%0d must be at least 1", BUS_WIDTH);
   end

   for (genvar b = 0; b < BUS_WIDTH; b++) begin : g_chain
      sync_bit_chain #(
         .NUM_STAGES (NUM_STAGES)
      ) u_chain (
         .CLK (CLK),
         .RST (RST),
         .d   (ASYNC[b]),
         .q   (SYNC[b])
      );
   end

endmodule : bit_synchronizer

// File: tb/tb_bit_synchronizer.sv
// Bench for bit_synchronizer: three instances (1 bit/4 stages, 8 bits/4 stages,
// 1 bit/2 stages) share clock and reset. Inputs change on falling edges and
// outputs are compared on the falling edge after each rising edge, both with
// directed expectations and against a history-based reference model.
module tb_bit_synchronizer;

   localparam int HIST = 1024;

   logic       clk_sys = 1'b0;
   logic       rst     = 1'b1;
   logic       async_1 = 1'b0;
   logic [7:0] async_8 = 8'h00;
   logic       async_2 = 1'b0;
   logic       sync_1;
   logic [7:0] sync_8;
   logic       sync_2;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Per rising edge: the value each DUT sampled and whether reset was high.
   logic [7:0] h_1 [HIST];
   logic [7:0] h_8 [HIST];
   logic [7:0] h_2 [HIST];
   logic       h_r [HIST];
   int         n_edges = 0;

   always #5 clk_sys = ~clk_sys;

   bit_synchronizer #(.BUS_WIDTH(1), .NUM_STAGES(4)) u_dut_1 (
      .CLK (clk_sys), .RST (rst), .ASYNC (async_1), .SYNC (sync_1)
   );

   bit_synchronizer #(.BUS_WIDTH(8), .NUM_STAGES(4)) u_dut_8 (
      .CLK (clk_sys), .RST (rst), .ASYNC (async_8), .SYNC (sync_8)
   );

   bit_synchronizer #(.BUS_WIDTH(1), .NUM_STAGES(2)) u_dut_2 (
      .CLK (clk_sys), .RST (rst), .ASYNC (async_2), .SYNC (sync_2)
   );

   always @(posedge clk_sys) begin
      if (n_edges < HIST) begin
         h_1[n_edges] = {7'd0, async_1};
         h_8[n_edges] = async_8;
         h_2[n_edges] = {7'd0, async_2};
         h_r[n_edges] = rst;
      end
      n_edges = n_edges + 1;
   end

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_compared = n_compared + 1;
      if (got !== exp) begin
         n_mismatched = n_mismatched + 1;
         $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Output after edge e is the sample taken ns-1 edges earlier, unless a
   // reset edge lies anywhere in that ns-edge window.
   function automatic logic [7:0] model_sync(input int e, input int ns, input int which);
      for (int k = 0; k < ns; k++) begin
         if (e - k < 0) return 8'h00;
         if (h_r[e - k]) return 8'h00;
      end
      case (which)
         0:       return h_1[e - ns + 1];
         1:       return h_8[e - ns + 1];
         default: return h_2[e - ns + 1];
      endcase
   endfunction

   // One cycle: drive at falling edge, pass a rising edge, compare at the next falling edge.
   task automatic step(input logic a1, input logic [7:0] a8, input logic a2, input logic r);
      int e;
      async_1 = a1;
      async_8 = a8;
      async_2 = a2;
      rst     = r;
      @(posedge clk_sys);
      @(negedge clk_sys);
      e = n_edges - 1;
      check_val("model_w1_s4", {7'd0, sync_1}, model_sync(e, 4, 0));
      check_val("model_w8_s4", sync_8,         model_sync(e, 4, 1));
      check_val("model_w1_s2", {7'd0, sync_2}, model_sync(e, 2, 2));
   endtask

   initial begin : main
      int pulses;
      logic [7:0] r8;

      // Reset with ASYNC high: cleared at the reset edge, 1 only at 4th post-reset edge.
      step(1'b1, 8'hFF, 1'b1, 1'b1);
      check_val("reset_sync1", {7'd0, sync_1}, 8'h00);
      check_val("reset_sync8", sync_8, 8'h00);
      check_val("reset_sync2", {7'd0, sync_2}, 8'h00);
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 8'hFF, 1'b1, 1'b0);
         check_val($sformatf("post_rst_e%0d", i), {7'd0, sync_1}, (i == 4) ? 8'h01 : 8'h00);
      end

      // Latency step 0 -> 1 on both depths.
      step(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 8'h00, 1'b1, 1'b0);
         check_val($sformatf("step_s4_e%0d", i), {7'd0, sync_1}, (i == 4) ? 8'h01 : 8'h00);
         if (i <= 2)
            check_val($sformatf("step_s2_e%0d", i), {7'd0, sync_2}, (i == 2) ? 8'h01 : 8'h00);
      end

      // Random stream against the model.
      for (int i = 0; i < 50; i++) begin
         r8 = 8'($urandom);
         step(1'($urandom), r8, 1'($urandom), 1'b0);
      end

      // Isolated one-cycle pulse must appear for exactly one cycle.
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
      pulses = 0;
      step(1'b1, 8'h00, 1'b1, 1'b0);
      pulses += int'(sync_1);
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 8'h00, 1'b0, 1'b0);
         pulses += int'(sync_1);
      end
      check_val("pulse_width", 8'(pulses), 8'h01);

      // Multi-bit: A5 then 3C, each visible exactly 4 cycles later with no skew.
      for (int i = 1; i <= 4; i++) begin
         step(1'b0, 8'hA5, 1'b0, 1'b0);
         check_val($sformatf("bus_a5_e%0d", i), sync_8, (i == 4) ? 8'hA5 : 8'h00);
      end
      for (int i = 1; i <= 4; i++) begin
         step(1'b0, 8'h3C, 1'b0, 1'b0);
         check_val($sformatf("bus_3c_e%0d", i), sync_8, (i == 4) ? 8'h3C : 8'hA5);
      end

      // Reset mid-stream discards 1,1,0,1 in flight.
      step(1'b1, 8'hFF, 1'b1, 1'b0);
      step(1'b1, 8'hFF, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 8'hFF, 1'b1, 1'b0);
      step(1'b1, 8'hFF, 1'b1, 1'b1);
      check_val("midrst_sync1", {7'd0, sync_1}, 8'h00);
      check_val("midrst_sync8", sync_8, 8'h00);
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 8'hFF, 1'b1, 1'b0);
         check_val($sformatf("midrst_e%0d", i), {7'd0, sync_1}, (i == 4) ? 8'h01 : 8'h00);
      end

      // Short random tail with occasional resets, model only.
      for (int i = 0; i < 30; i++) begin
         r8 = 8'($urandom);
         step(1'($urandom), r8, 1'($urandom), ($urandom_range(0, 9) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule : tb_bit_synchronizer
